// File: rtl/rr_mux_sched_if.sv
// Request/data/grant bundle for the round-robin 8:1 mux scheduler.
// master drives requests and data; slave is the scheduler.
interface rr_mux_sched_if;
    logic [7:0] req;
    logic [7:0] i;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;
    logic       y_vld;

    modport master (
        output req, i,
        input  sel, gnt, busy, y, y_vld
    );

    modport slave (
        input  req, i,
        output sel, gnt, busy, y, y_vld
    );
endinterface

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler for a shared 8:1 one-bit mux with bounded bursts.
// Registers the selected bit with a qualifying valid.
module rr_mux_sched #(
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux_sched_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_W = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       y_q, y_d;
    logic       y_vld_q, y_vld_d;

    logic       arb_found;
    logic [2:0] arb_idx;
    logic [2:0] cand;
    logic       keep;

    // Find first requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 3'd0;
        cand      = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!arb_found && bus.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Holder keeps the mux while it still requests and has budget left.
    assign keep = bus.req[sel_q] && (cnt_q < HOLD_W);

    // Next-state: burst hold, release with immediate re-arbitration.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        y_d     = bus.i[sel_q];
        y_vld_d = busy_q & bus.req[sel_q];

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    ptr_d   = arb_idx + 3'd1;
                    cnt_d   = 8'd1;
                    sel_d   = arb_idx;
                    gnt_d   = 8'd1 << arb_idx;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (keep) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (arb_found) begin
                    ptr_d  = arb_idx + 3'd1;
                    cnt_d  = 8'd1;
                    sel_d  = arb_idx;
                    gnt_d  = 8'd1 << arb_idx;
                    busy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    gnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            y_q     <= 1'b0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.y     = y_q;
    assign bus.y_vld = y_vld_q;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Bench for rr_mux_sched: directed and random stimulus against a
// queue-fed reference model, checked by an independent monitor.
module tb_rr_mux_sched;

    localparam int HOLD = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
        logic       yvld;
    } exp_t;

    logic clk;
    logic rst;

    rr_mux_sched_if bus ();

    rr_mux_sched #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: who holds the mux, for how long, where the
    // round-robin search starts, and what the output register holds.
    int m_holder = -1;
    int m_sel    = 0;
    int m_cnt    = 0;
    int m_ptr    = 0;
    bit m_y      = 0;
    bit m_yvld   = 0;

    function automatic int pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_step(input bit r_rst,
                                       input logic [7:0] r,
                                       input logic [7:0] d);
        exp_t e;
        int   w;
        if (r_rst) begin
            m_holder = -1; m_sel = 0; m_cnt = 0; m_ptr = 0;
            m_y = 0; m_yvld = 0;
        end else begin
            m_y    = d[m_sel];
            m_yvld = (m_holder >= 0) && r[m_sel];
            if (m_holder >= 0 && r[m_holder] && m_cnt < HOLD) begin
                m_cnt++;
            end else begin
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_holder = w; m_sel = w; m_cnt = 1;
                    m_ptr = (w + 1) % 8;
                end else begin
                    m_holder = -1; m_cnt = 0;
                end
            end
        end
        e.busy = (m_holder >= 0);
        e.gnt  = e.busy ? (8'd1 << m_holder) : 8'd0;
        e.sel  = 3'(m_sel);
        e.y    = m_y;
        e.yvld = m_yvld;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit r_rst, input logic [7:0] r,
                         input logic [7:0] d);
        @(negedge clk);
        rst     = r_rst;
        bus.req = r;
        bus.i   = d;
        model_step(r_rst, r, d);
    endtask

    // Monitor: after every edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ok = (bus.gnt === e.gnt) && (bus.busy === e.busy)
                  && (bus.y_vld === e.yvld)
                  && (!e.busy || bus.sel === e.sel)
                  && (!e.yvld || bus.y === e.y);
                n_checks++;
                if (ok) n_pass++;
                else $display("FAIL cyc%0d outputs: got gnt=%h sel=%0d busy=%b y=%b vld=%b want gnt=%h sel=%0d busy=%b y=%b vld=%b",
                    cyc, bus.gnt, bus.sel, bus.busy, bus.y, bus.y_vld,
                    e.gnt, e.sel, e.busy, e.y, e.yvld);
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst     = 1'b1;
        bus.req = 8'hFF;
        bus.i   = 8'h00;

        // Reset with everyone requesting, then full contention.
        drive(1, 8'hFF, 8'h00);
        drive(1, 8'hFF, 8'h00);
        for (int k = 0; k < 36; k++) drive(0, 8'hFF, 8'hA5);

        // Single requester re-granting itself.
        drive(1, 8'h00, 8'h00);
        for (int k = 0; k < 10; k++) drive(0, 8'h08, 8'hFF);

        // Early drop of requester 5 after two grant cycles.
        drive(1, 8'h00, 8'h00);
        for (int k = 0; k < 6; k++) drive(0, 8'h22, 8'h20);
        for (int k = 0; k < 4; k++) drive(0, 8'h02, 8'h22);
        for (int k = 0; k < 3; k++) drive(0, 8'h00, 8'h00);

        // Reset in the middle of a burst to requester 4.
        drive(1, 8'h00, 8'h00);
        drive(0, 8'h10, 8'h10);
        drive(0, 8'h10, 8'h10);
        drive(1, 8'h10, 8'h10);
        for (int k = 0; k < 4; k++) drive(0, 8'h11, 8'h01);

        // Random traffic with occasional resets and idle periods.
        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            if ($urandom_range(0, 3) == 0) r = r & 8'h0F;
            drive(($urandom_range(0, 59) == 0), r, 8'($urandom));
        end

        // Let the monitor drain every outstanding expectation.
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
